// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//
// AHB-Lite slave in front of a word-organised internal SRAM. Accepts BYTE,
// HALFWORD and WORD transfers, optionally stretches every OKAY data phase by
// WAIT_STATES cycles, and answers misaligned, oversized or out-of-range
// accesses with the two-cycle AHB ERROR response. Errored transfers never
// touch storage.
//
// Parameters:
//   MEM_DEPTH    number of 32-bit words of storage (power of two, 4..1024)
//   WAIT_STATES  wait cycles inserted before each OKAY completion (0..7)
//
// Ports:
//   hclk        in   sole clock, rising edge
//   hreset      in   asynchronous, active-high reset
//   hsel        in   slave select from the address decoder
//   haddr       in   byte address (address phase)
//   hwrite      in   1 = write, 0 = read
//   hsize       in   transfer size (0 BYTE, 1 HALFWORD, 2 WORD)
//   hburst      in   burst type, ignored
//   hprot       in   protection, ignored
//   htrans      in   transfer type (IDLE, BUSY, NONSEQ, SEQ)
//   hmastlock   in   locked transfer, ignored
//   hwdata      in   write data (data phase)
//   hready      in   bus-level ready; previous transfer completes when high
//   hreadyout   out  slave ready
//   hrdata      out  read data, zero outside an OKAY read completion
//   hresp       out  0 = OKAY, 1 = ERROR

module ahb_sram_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic        hmastlock,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic [31:0] hrdata,
    output logic        hresp
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Counter preload for the wait sequence; the FSM only reads it when
    // WAIT_STATES > 0, so the value for the zero case is never used.
    localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t           state;
    logic [2:0]       wait_cnt;

    // Registered address phase of the transfer currently in its data phase.
    logic             pending;     // an OKAY transfer owns the data phase
    logic             d_write;
    logic [IDX_W-1:0] d_index;
    logic [1:0]       d_size;
    logic [1:0]       d_lane;

    logic [31:0]      mem [MEM_DEPTH];

    logic             accept;
    logic             addr_err;
    logic             commit;
    logic [3:0]       lane_en;

    // Bus attributes this slave has no use for.
    logic             unused_inputs;
    assign unused_inputs = ^{hburst, hprot, hmastlock};

    // A new address phase is only looked at when the previous data phase is
    // finishing on this cycle: the normal idle state, or the second ERROR
    // cycle (which completes the errored transfer). htrans[1] covers NONSEQ
    // and SEQ.
    assign accept = hsel && hready && htrans[1] &&
                    ((state == ST_IDLE) || (state == ST_ERR2));

    // NOTE: every variable driven here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        addr_err = 1'b0;
        case (hsize)
            HSIZE_BYTE: addr_err = 1'b0;
            HSIZE_HALF: addr_err = haddr[0];
            HSIZE_WORD: addr_err = |haddr[1:0];
            default:    addr_err = 1'b1;
        endcase
        if (haddr[31:2] >= 30'(MEM_DEPTH)) begin
            addr_err = 1'b1;
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so all
    // flops update together from pre-edge values.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 3'd0;
            pending   <= 1'b0;
            d_write   <= 1'b0;
            d_index   <= '0;
            d_size    <= 2'd0;
            d_lane    <= 2'd0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    // Whatever was in the data phase completes on this edge.
                    state     <= ST_IDLE;
                    pending   <= 1'b0;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    if (accept) begin
                        d_write <= hwrite;
                        d_index <= haddr[IDX_W+1:2];
                        d_size  <= hsize[1:0];
                        d_lane  <= haddr[1:0];
                        if (addr_err) begin
                            state     <= ST_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                        end else begin
                            pending <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                state     <= ST_WAIT;
                                wait_cnt  <= WAIT_LOAD;
                                hreadyout <= 1'b0;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    // The cycle after the counter hits zero is the
                    // completing cycle, so WAIT_STATES stall cycles result.
                    if (wait_cnt == 3'd0) begin
                        state     <= ST_IDLE;
                        hreadyout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
            endcase
        end
    end

    // Little-endian byte-lane enables of the pending transfer.
    always_comb begin
        lane_en = 4'b0000;
        case (d_size)
            2'd0:    lane_en[d_lane] = 1'b1;
            2'd1:    lane_en = d_lane[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // A write lands on the edge that ends its completing data-phase cycle.
    // Reset clears pending asynchronously, so an interrupted write never
    // reaches the array.
    assign commit = pending && d_write && hreadyout;

    // NOTE: the storage array has no reset; its contents survive hreset and
    // it can map onto a plain SRAM macro.
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[d_index][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Read data comes straight from the array during the completing cycle.
    // A write that completed on the previous edge is already in the array,
    // so a read issued back-to-back behind it sees the new value.
    assign hrdata = (pending && !d_write && hreadyout) ? mem[d_index] : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
//
// Two slave instances on one shared bus (WAIT_STATES 0 and 3); hready is
// taken from whichever slave is being addressed. A pipelined master model
// runs queued transfers, and every data-phase cycle is compared against a
// byte-addressed reference memory and the expected response timing.

module tb_ahb_sram_slave;

    localparam int DEPTH = 256;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        hclk;
    logic        hreset;
    logic        hsel0;
    logic        hsel1;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic        ro0;
    logic        ro1;
    logic        resp0;
    logic        resp1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        tgt;

    assign hready = tgt ? ro1 : ro0;

    ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel0),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hprot     (hprot),
        .htrans    (htrans),
        .hmastlock (hmastlock),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (ro0),
        .hrdata    (rdata0),
        .hresp     (resp0)
    );

    ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_dut1 (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel1),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hprot     (hprot),
        .htrans    (htrans),
        .hmastlock (hmastlock),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (ro1),
        .hrdata    (rdata1),
        .hresp     (resp1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_checks;
    int n_pass;

    xfer_t       q[$];
    xfer_t       dp;
    bit          dp_valid;
    bit          dp_err;
    int          dp_k;
    logic [31:0] model_mem [2][DEPTH];
    bit          known [2][DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                                 input logic [31:0] d);
        xfer_t t;
        t.sel   = 1'b1;
        t.trans = T_NONSEQ;
        t.write = wr;
        t.addr  = a;
        t.size  = sz;
        t.wdata = d;
        return t;
    endfunction

    function automatic xfer_t idle_xfer();
        xfer_t t;
        t.sel   = 1'b0;
        t.trans = T_IDLE;
        t.write = 1'b0;
        t.addr  = 32'd0;
        t.size  = 3'd0;
        t.wdata = 32'd0;
        return t;
    endfunction

    // Error rule from the access itself: size beyond WORD, address not a
    // multiple of the access size, or word index beyond the array.
    function automatic bit is_err(input xfer_t t);
        if (t.size > 3'd2) return 1'b1;
        if ((t.addr % (32'd1 << t.size)) != 32'd0) return 1'b1;
        if ((t.addr >> 2) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    // Byte-by-byte store: byte at address A lives in word A/4, bits 8*(A%4).
    task automatic model_write(input xfer_t t);
        int w;
        int lane;
        w = int'(t.addr >> 2);
        for (int b = 0; b < (1 << t.size); b++) begin
            lane = int'((t.addr + b) % 4);
            model_mem[tgt][w][8*lane +: 8] = t.wdata[8*lane +: 8];
        end
        if (t.size == 3'd2) known[tgt][w] = 1'b1;
    endtask

    task automatic present(input xfer_t t);
        hsel0     = (tgt == 1'b0) && t.sel;
        hsel1     = (tgt == 1'b1) && t.sel;
        htrans    = t.trans;
        hwrite    = t.write;
        haddr     = t.addr;
        hsize     = t.size;
        hburst    = 3'($urandom);
        hprot     = 4'($urandom);
        hmastlock = 1'($urandom);
    endtask

    // One bus cycle, called at the falling edge: check the data phase in
    // progress, then drive what the next rising edge will sample.
    task automatic bus_cycle();
        logic        ro;
        logic        rs;
        logic [31:0] rd;
        bit          exp_ro;
        int          ws;
        int          w;
        ro = tgt ? ro1 : ro0;
        rs = tgt ? resp1 : resp0;
        rd = tgt ? rdata1 : rdata0;
        ws = tgt ? 3 : 0;
        hwdata = (dp_valid && dp.write) ? dp.wdata : $urandom;
        if (dp_valid) begin
            dp_k++;
            exp_ro = dp_err ? (dp_k >= 2) : (dp_k >= ws + 1);
            check($sformatf("hreadyout a=%08h k=%0d", dp.addr, dp_k), 32'(ro), 32'(exp_ro));
            check($sformatf("hresp a=%08h k=%0d", dp.addr, dp_k), 32'(rs), 32'(dp_err));
            if (!dp_err && exp_ro && !dp.write) begin
                w = int'(dp.addr >> 2);
                if (known[tgt][w]) begin
                    check($sformatf("hrdata a=%08h", dp.addr), rd, model_mem[tgt][w]);
                end
            end else begin
                check($sformatf("hrdata_zero a=%08h k=%0d", dp.addr, dp_k), rd, 32'd0);
            end
            if (dp_k > 10) dp_valid = 1'b0;
        end else begin
            check("idle_hreadyout", 32'(ro), 32'd1);
            check("idle_hresp", 32'(rs), 32'd0);
            check("idle_hrdata", rd, 32'd0);
        end
        if (ro) begin
            if (dp_valid && !dp_err && dp.write) model_write(dp);
            dp_valid = 1'b0;
            if (q.size() > 0) begin
                present(q[0]);
                if (q[0].sel && q[0].trans[1]) begin
                    dp       = q[0];
                    dp_valid = 1'b1;
                    dp_err   = is_err(q[0]);
                    dp_k     = 0;
                end
                void'(q.pop_front());
            end else begin
                present(idle_xfer());
            end
        end else begin
            if (q.size() > 0) present(q[0]);
            else present(idle_xfer());
        end
    endtask

    task automatic run_queue();
        int budget;
        int cycles;
        budget = 12 * q.size() + 20;
        cycles = 0;
        while ((q.size() > 0 || dp_valid) && cycles < budget) begin
            @(negedge hclk);
            bus_cycle();
            cycles++;
        end
        check("queue_drained", 32'(q.size()) + (dp_valid ? 32'd1 : 32'd0), 32'd0);
        q.delete();
        dp_valid = 1'b0;
    endtask

    function automatic xfer_t rand_xfer();
        xfer_t t;
        int    r;
        r       = int'($urandom_range(0, 99));
        t.sel   = (r >= 5);
        t.trans = (r < 12) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        t.write = 1'($urandom);
        t.wdata = $urandom;
        r       = int'($urandom_range(0, 99));
        t.size  = (r < 8) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        r       = int'($urandom_range(0, 99));
        if (r < 5) begin
            t.addr = 32'(DEPTH * 4) + $urandom_range(0, 255);
        end else begin
            t.addr = $urandom_range(0, 79);
            if (r < 80 && t.size <= 3'd2) t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
        end
        return t;
    endfunction

    task automatic prefill_and_random(input int n);
        for (int i = 0; i < 20; i++) q.push_back(mk(1'b1, 32'(4 * i), 3'd2, $urandom));
        run_queue();
        for (int i = 0; i < n; i++) q.push_back(rand_xfer());
        run_queue();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t t;
        n_checks = 0;
        n_pass   = 0;
        tgt      = 1'b0;
        dp_valid = 1'b0;
        hwdata   = 32'd0;
        hreset   = 1'b0;
        present(idle_xfer());

        // Reset must act before any clock edge.
        #1 hreset = 1'b1;
        #1;
        check("rst_hreadyout0", 32'(ro0), 32'd1);
        check("rst_hresp0", 32'(resp0), 32'd0);
        check("rst_hrdata0", rdata0, 32'd0);
        check("rst_hreadyout1", 32'(ro1), 32'd1);
        check("rst_hresp1", 32'(resp1), 32'd0);
        check("rst_hrdata1", rdata1, 32'd0);
        repeat (2) @(negedge hclk);
        hreset = 1'b0;

        // Zero-wait slave: directed cases.
        q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
        q.push_back(mk(1'b1, 32'h10, 3'd2, 32'h11223344));
        q.push_back(mk(1'b1, 32'h13, 3'd0, 32'hAA000000));
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
        q.push_back(mk(1'b1, 32'h00, 3'd2, 32'h12345678));
        q.push_back(mk(1'b0, 32'h02, 3'd2, 32'd0));
        q.push_back(mk(1'b1, 32'h02, 3'd2, 32'hFFFFFFFF));
        q.push_back(mk(1'b0, 32'h00, 3'd2, 32'd0));
        q.push_back(mk(1'b1, 32'h20, 3'd2, 32'h0000CAFE));
        q.push_back(mk(1'b0, 32'h20, 3'd2, 32'd0));
        q.push_back(mk(1'b1, 32'h14, 3'd2, 32'h00000000));
        q.push_back(mk(1'b1, 32'h16, 3'd1, 32'hBEEF0000));
        q.push_back(mk(1'b1, 32'h15, 3'd1, 32'h55555555));
        q.push_back(mk(1'b1, 32'h18, 3'd3, 32'h66666666));
        q.push_back(mk(1'b0, 32'h14, 3'd2, 32'd0));
        q.push_back(mk(1'b1, 32'h400, 3'd2, 32'h77777777));
        q.push_back(mk(1'b1, 32'h3FC, 3'd2, 32'hA5A5C3C3));
        q.push_back(mk(1'b0, 32'h3FC, 3'd2, 32'd0));
        t = mk(1'b1, 32'h10, 3'd2, 32'h99999999);
        t.sel = 1'b0;
        q.push_back(t);
        t = mk(1'b1, 32'h10, 3'd2, 32'h88888888);
        t.trans = T_BUSY;
        q.push_back(t);
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
        run_queue();
        prefill_and_random(300);

        // Three-wait-state slave.
        tgt = 1'b1;
        q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
        q.push_back(mk(1'b0, 32'h02, 3'd2, 32'd0));
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
        run_queue();
        prefill_and_random(80);

        // Reset in the middle of a waited write: old word must survive.
        q.push_back(mk(1'b1, 32'h40, 3'd2, 32'h55AA55AA));
        run_queue();
        @(negedge hclk);
        present(mk(1'b1, 32'h40, 3'd2, 32'd0));
        @(negedge hclk);
        present(idle_xfer());
        hwdata = 32'h0BADF00D;
        check("wait_before_reset", 32'(ro1), 32'd0);
        #2 hreset = 1'b1;
        #1;
        check("midrst_hreadyout", 32'(ro1), 32'd1);
        check("midrst_hresp", 32'(resp1), 32'd0);
        check("midrst_hrdata", rdata1, 32'd0);
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        q.push_back(mk(1'b0, 32'h40, 3'd2, 32'd0));
        run_queue();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256: number of 32-bit words of internal storage (power of two, 4..1024).
REQ-002 The block SHALL have parameter WAIT_STATES, default 0: wait cycles inserted before completing each OKAY transfer (0..7).
REQ-003 hclk  input  1  sole clock; all state updates on the rising edge.
REQ-004 hreset  input  1  reset, asynchronous and active-high.
REQ-005 hsel  input  1  slave select from the address decoder.
REQ-006 haddr  input  32  byte address.
REQ-007 hwrite  input  1  1 = write, 0 = read.
REQ-008 hsize  input  3  transfer size, AHB_package hsize_type.
REQ-009 hburst  input  3  burst type, AHB_package hburst_type; accepted but ignored.
REQ-010 hprot  input  4  protection; ignored.
REQ-011 htrans  input  2  transfer type, AHB_package htrans_type.
REQ-012 hmastlock  input  1  locked transfer; ignored.
REQ-013 hwdata  input  32  write data, valid in the data phase.
REQ-014 hready  input  1  bus-level ready; the previous transfer completes when high.
REQ-015 hreadyout  output  1  slave ready.
REQ-016 hrdata  output  32  read data.
REQ-017 hresp  output  1  0 = OKAY, 1 = ERROR.

Function
REQ-018 A transfer SHALL be accepted when hsel=1, hready=1 and htrans is NONSEQ or SEQ; haddr, hwrite and hsize SHALL be registered at that edge.
REQ-019 With hsel=0, or with htrans IDLE or BUSY, the block SHALL give a zero-wait OKAY response and change no storage.
REQ-020 An accepted transfer SHALL be flagged as an error in any of these cases:
- hsize above WORD;
- HALFWORD with haddr[0]=1;
- WORD with haddr[1:0]!=0;
- haddr[31:2] >= MEM_DEPTH.
REQ-021 The FSM SHALL have four states: ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2.
REQ-022 FSM transitions from ST_IDLE on an accepted transfer:
- error -> ST_ERR1;
- WAIT_STATES>0 -> ST_WAIT, with the wait counter loaded to WAIT_STATES-1;
- otherwise remain in ST_IDLE.
REQ-023 In ST_WAIT, hreadyout SHALL be 0 and hresp 0; the counter decrements; when it reaches 0, the FSM returns to ST_IDLE in the completing cycle with hreadyout=1.
REQ-024 In ST_ERR1, hreadyout SHALL be 0 and hresp 1; next state is ST_ERR2.
REQ-025 In ST_ERR2, hreadyout SHALL be 1 and hresp 1; the address phase sampled in this cycle SHALL be handled exactly as from ST_IDLE, including an IDLE cancel.
REQ-026 In ST_IDLE, hreadyout SHALL be 1 and hresp 0.
REQ-027 Writes SHALL commit on the data-phase cycle with hreadyout=1, using little-endian lane select:
- BYTE: lane haddr[1:0];
- HALFWORD: lanes haddr[1]*2 and haddr[1]*2+1;
- WORD: all four lanes.
REQ-028 Errored transfers SHALL never modify storage.
REQ-029 For an OKAY read data phase, hrdata SHALL be the full 32-bit word at the registered index; in all other cycles it SHALL be 0.
REQ-030 A read whose address phase coincides with the data phase of a write to the same word SHALL return the newly written data.
REQ-031 Back-to-back accepted transfers with WAIT_STATES=0 SHALL sustain one transfer per cycle.

Reset
REQ-032 While hreset=1, the block SHALL be in ST_IDLE with hreadyout=1, hresp=0, hrdata=0, the wait counter at 0 and no pending transfer; this takes effect immediately, without a clock edge.
REQ-033 Reset asserted mid-transfer SHALL abandon that transfer with no storage write; storage contents are not reset.

Verification
REQ-034 WAIT_STATES=0: WORD write 0xDEADBEEF to 0x10, then read 0x10 -> hrdata=0xDEADBEEF, hresp=0, no wait cycles.
REQ-035 Byte write 0xAA to 0x13 over word 0x11223344 at 0x10 -> read returns 0xAA223344.
REQ-036 WORD read at 0x2 -> hreadyout 0/1 with hresp 1/1 over two cycles; storage is unchanged.
REQ-037 WAIT_STATES=3, read -> hreadyout=0 for exactly 3 cycles, then 1 with valid data.
REQ-038 Write 0x0000CAFE to 0x20 immediately followed by a read of 0x20 -> read returns 0x0000CAFE.
REQ-039 hreset asserted during ST_WAIT of a write -> outputs are at their reset values at once and the target word keeps its old value.
